// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite encodings and the load/store bridge state type.
// Imported by the LSU master; also usable by other AXI-Lite blocks in the core.
package axi_lite_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } lsu_state_e;

    // Anything other than OKAY is reported to the core as an error, EXOKAY included.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        case (resp)
            AXI_RESP_OKAY:   err = 1'b0;
            AXI_RESP_EXOKAY: err = 1'b1;
            AXI_RESP_SLVERR: err = 1'b1;
            AXI_RESP_DECERR: err = 1'b1;
            default:         err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_axi_lite_master.sv
// Load/store bridge: turns one core data-memory request into a single AXI4-Lite
// read or write, stalling the core until the response has been returned.
module lsu_axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  stall,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [2:0]            m_awprot,
    output logic [2:0]            m_arprot
);

    lsu_state_e              state_r;
    logic [ADDR_W-1:0]       addr_r;
    logic [DATA_W-1:0]       wdata_r;
    logic [DATA_W/8-1:0]     wstrb_r;
    logic                    aw_done_r;
    logic                    w_done_r;

    logic                    aw_hs_s;
    logic                    w_hs_s;
    logic                    aw_ok_s;
    logic                    w_ok_s;

    assign aw_hs_s = m_awvalid && m_awready;
    assign w_hs_s  = m_wvalid && m_wready;
    assign aw_ok_s = aw_done_r || aw_hs_s;
    assign w_ok_s  = w_done_r || w_hs_s;

    // Payload registers only change in IDLE, so they stay constant while any valid is up.
    assign m_awaddr = addr_r;
    assign m_araddr = addr_r;
    assign m_wdata  = wdata_r;
    assign m_wstrb  = wstrb_r;
    assign m_awprot = 3'b000;
    assign m_arprot = 3'b000;

    // The core is released in DONE so it advances on that edge.
    assign stall = req_valid && (state_r != DONE);

    // Transaction FSM with registered AXI handshake and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            wstrb_r   <= {(DATA_W/8){1'b0}};
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= {DATA_W{1'b0}};
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        addr_r  <= {req_addr[ADDR_W-1:2], 2'b00};
                        wdata_r <= req_wdata;
                        wstrb_r <= req_wstrb;
                        if (req_we) begin
                            state_r   <= WR;
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                            aw_done_r <= 1'b0;
                            w_done_r  <= 1'b0;
                        end else begin
                            state_r   <= RD_ADDR;
                            m_arvalid <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (aw_hs_s) begin
                        m_awvalid <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        m_wvalid <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    // The later assignments win, so both flags are cleared on exit.
                    if (aw_ok_s && w_ok_s) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        m_bready  <= 1'b1;
                        state_r   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_bvalid) begin
                        m_bready  <= 1'b0;
                        rsp_err   <= resp_is_err(m_bresp);
                        rsp_valid <= 1'b1;
                        state_r   <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state_r   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_rvalid) begin
                        m_rready  <= 1'b0;
                        rsp_rdata <= m_rdata;
                        rsp_err   <= resp_is_err(m_rresp);
                        rsp_valid <= 1'b1;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    m_awvalid <= 1'b0;
                    m_wvalid  <= 1'b0;
                    m_bready  <= 1'b0;
                    m_arvalid <= 1'b0;
                    m_rready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_axi_lite_master.sv
// Bench for lsu_axi_lite_master: a delay-configurable AXI-Lite slave, a transaction-level
// reference model checked every cycle, and directed requests with literal expectations.
module tb_lsu_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        stall, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;
    logic [2:0]  m_awprot, m_arprot;

    always #5 clk = ~clk;

    lsu_axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awprot(m_awprot), .m_arprot(m_arprot)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    // ---------------- slave model ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  slv_bresp = 2'b00, slv_rresp = 2'b00;
    logic [31:0] slv_rdata = 32'h0;
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic        aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    logic        aw_ok, w_ok;

    assign m_awready = (aw_wait >= aw_dly);
    assign m_wready  = (w_wait >= w_dly);
    assign m_arready = (ar_wait >= ar_dly);
    assign m_bvalid  = b_pend && (b_wait >= b_dly);
    assign m_rvalid  = r_pend && (r_wait >= r_dly);
    assign m_bresp   = slv_bresp;
    assign m_rresp   = slv_rresp;
    assign m_rdata   = slv_rdata;
    assign aw_ok     = aw_got || (m_awvalid && m_awready);
    assign w_ok      = w_got || (m_wvalid && m_wready);

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            aw_wait <= (m_awvalid && !m_awready) ? aw_wait + 1 : 0;
            w_wait  <= (m_wvalid && !m_wready) ? w_wait + 1 : 0;
            ar_wait <= (m_arvalid && !m_arready) ? ar_wait + 1 : 0;
            b_wait  <= (b_pend && !(m_bvalid && m_bready)) ? b_wait + 1 : 0;
            r_wait  <= (r_pend && !(m_rvalid && m_rready)) ? r_wait + 1 : 0;
            aw_got  <= (aw_ok && w_ok) ? 1'b0 : aw_ok;
            w_got   <= (aw_ok && w_ok) ? 1'b0 : w_ok;
            if (m_bvalid && m_bready) b_pend <= 1'b0;
            else if (aw_ok && w_ok)   b_pend <= 1'b1;
            if (m_rvalid && m_rready)       r_pend <= 1'b0;
            else if (m_arvalid && m_arready) r_pend <= 1'b1;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0;
    logic [3:0]  exp_wstrb = 4'h0;
    logic        exp_rsp_pulse = 1'b0, exp_err = 1'b0, exp_is_load = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int          aw_vcyc = 0, w_vcyc = 0, ar_vcyc = 0, rdy_cyc = 0;
    logic [31:0] last_awaddr = 32'h0;
    logic        aw_hold = 1'b0, w_hold = 1'b0, ar_hold = 1'b0;
    logic [31:0] aw_hold_addr = 32'h0, w_hold_data = 32'h0, ar_hold_addr = 32'h0;

    // Handshake-level model: payload checks, valid/payload stability, response expectations.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_rsp_pulse <= 1'b0;
            aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
        end else begin
            if (aw_hold) begin
                check("awvalid_held", {31'b0, m_awvalid}, 32'h1);
                check("awaddr_held", m_awaddr, aw_hold_addr);
            end
            if (w_hold) begin
                check("wvalid_held", {31'b0, m_wvalid}, 32'h1);
                check("wdata_held", m_wdata, w_hold_data);
            end
            if (ar_hold) begin
                check("arvalid_held", {31'b0, m_arvalid}, 32'h1);
                check("araddr_held", m_araddr, ar_hold_addr);
            end
            aw_hold <= m_awvalid && !m_awready; aw_hold_addr <= m_awaddr;
            w_hold  <= m_wvalid && !m_wready;   w_hold_data  <= m_wdata;
            ar_hold <= m_arvalid && !m_arready; ar_hold_addr <= m_araddr;
            if (m_awvalid && m_awready) begin
                aw_cnt <= aw_cnt + 1;
                last_awaddr <= m_awaddr;
                check("awaddr", m_awaddr, exp_addr);
                check("awprot", {29'b0, m_awprot}, 32'h0);
            end
            if (m_wvalid && m_wready) begin
                w_cnt <= w_cnt + 1;
                check("wdata", m_wdata, exp_wdata);
                check("wstrb", {28'b0, m_wstrb}, {28'b0, exp_wstrb});
            end
            if (m_arvalid && m_arready) begin
                ar_cnt <= ar_cnt + 1;
                check("araddr", m_araddr, exp_addr);
                check("arprot", {29'b0, m_arprot}, 32'h0);
            end
            if (m_bvalid && m_bready) begin
                b_cnt <= b_cnt + 1;
                exp_is_load <= 1'b0;
                exp_err <= (slv_bresp != 2'b00);
            end
            if (m_rvalid && m_rready) begin
                r_cnt <= r_cnt + 1;
                exp_is_load <= 1'b1;
                exp_err <= (slv_rresp != 2'b00);
                exp_rdata <= slv_rdata;
            end
            exp_rsp_pulse <= (m_bvalid && m_bready) || (m_rvalid && m_rready);
            if (m_awvalid) aw_vcyc <= aw_vcyc + 1;
            if (m_wvalid)  w_vcyc  <= w_vcyc + 1;
            if (m_arvalid) ar_vcyc <= ar_vcyc + 1;
            if (m_bready || m_rready) rdy_cyc <= rdy_cyc + 1;
        end
    end

    // Per-cycle comparison of core-facing outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rsp_pulse});
            check("stall", {31'b0, stall}, {31'b0, req_valid && !exp_rsp_pulse});
            if (exp_rsp_pulse) begin
                check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
                if (exp_is_load) check("rsp_rdata", rsp_rdata, exp_rdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    int          t_done, t_stall, d_aw, d_w, d_b, d_ar, d_r, d_awv, d_wv;
    logic        t_err;
    logic [31:0] t_rdata;

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb);
        int aw0, w0, b0, ar0, r0, awv0, wv0;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
        awv0 = aw_vcyc; wv0 = w_vcyc;
        exp_addr = addr & 32'hFFFF_FFFC; exp_wdata = wdata; exp_wstrb = strb;
        req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb; req_valid = 1'b1;
        t_done = 0; t_stall = 0; t_err = 1'b0; t_rdata = 32'h0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (stall) t_stall++;
            if (rsp_valid) begin
                t_done = c; t_err = rsp_err; t_rdata = rsp_rdata;
                break;
            end
        end
        if (t_done == 0) begin
            n_tests++; n_fail++;
            $display("FAIL timeout: no rsp_valid for addr 0x%08h within 200 cycles", addr);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        d_aw = aw_cnt - aw0; d_w = w_cnt - w0; d_b = b_cnt - b0;
        d_ar = ar_cnt - ar0; d_r = r_cnt - r0;
        d_awv = aw_vcyc - awv0; d_wv = w_vcyc - wv0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int q0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {24'b0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                             rsp_valid, rsp_err, stall}, 32'h0);
        check("reset_rdata", rsp_rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Minimum-latency store
        do_req(1'b1, 32'h0000_1003, 32'hDEAD_BEEF, 4'hF);
        check("st1_done_cycle", t_done, 4);
        check("st1_stall_cycles", t_stall, 3);
        check("st1_awaddr", last_awaddr, 32'h0000_1000);
        check("st1_err", {31'b0, t_err}, 32'h0);
        check("st1_hs", {d_aw[7:0], d_w[7:0], d_b[7:0], d_ar[7:0]}, 32'h0101_0100);

        // W accepted three cycles after AW
        w_dly = 3;
        do_req(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'h3);
        w_dly = 0;
        check("st2_done_cycle", t_done, 7);
        check("st2_awvalid_cycles", d_awv, 1);
        check("st2_wvalid_cycles", d_wv, 4);
        check("st2_b_hs", d_b, 1);

        // AW accepted after W, write response one cycle late with DECERR
        aw_dly = 2; b_dly = 1; slv_bresp = 2'b11;
        do_req(1'b1, 32'h0000_10F2, 32'h0102_0304, 4'h4);
        aw_dly = 0; b_dly = 0; slv_bresp = 2'b00;
        check("st3_done_cycle", t_done, 7);
        check("st3_err", {31'b0, t_err}, 32'h1);

        // Load with AR delayed two cycles
        ar_dly = 2; slv_rdata = 32'h1234_5678;
        do_req(1'b0, 32'h0000_2000, 32'h0, 4'h0);
        ar_dly = 0;
        check("ld1_done_cycle", t_done, 6);
        check("ld1_rdata", t_rdata, 32'h1234_5678);
        check("ld1_hs", {d_aw[7:0], d_b[7:0], d_ar[7:0], d_r[7:0]}, 32'h0000_0101);

        // SLVERR load, then an OKAY store clears the error
        slv_rresp = 2'b10; slv_rdata = 32'hCAFE_F00D;
        do_req(1'b0, 32'h0000_3002, 32'h0, 4'h0);
        slv_rresp = 2'b00;
        check("ld2_done_cycle", t_done, 4);
        check("ld2_err", {31'b0, t_err}, 32'h1);
        do_req(1'b1, 32'h0000_3000, 32'h5555_AAAA, 4'h9);
        check("st4_err", {31'b0, t_err}, 32'h0);

        // Back-to-back store then load with R delayed one cycle
        r_dly = 1; slv_rdata = 32'h0BAD_F00D;
        do_req(1'b1, 32'h0000_0040, 32'h1111_2222, 4'hF);
        check("b2b_st_done", t_done, 4);
        check("b2b_st_hs", {d_aw[7:0], d_w[7:0], d_b[7:0], d_ar[7:0]}, 32'h0101_0100);
        do_req(1'b0, 32'h0000_0045, 32'h0, 4'h0);
        r_dly = 0;
        check("b2b_ld_done", t_done, 5);
        check("b2b_ld_hs", {d_aw[7:0], d_w[7:0], d_ar[7:0], d_r[7:0]}, 32'h0000_0101);
        check("b2b_ld_rdata", t_rdata, 32'h0BAD_F00D);

        // No request: the AXI side stays quiet
        q0 = aw_vcyc + w_vcyc + ar_vcyc + rdy_cyc;
        repeat (5) @(posedge clk);
        #1;
        check("idle_quiet", aw_vcyc + w_vcyc + ar_vcyc + rdy_cyc - q0, 0);

        // Reset while AW is pending in WR
        aw_dly = 5; w_dly = 5;
        exp_addr = 32'h0000_5000;
        req_we = 1'b1; req_addr = 32'h0000_5000; req_wdata = 32'h7777_7777; req_wstrb = 4'hF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_pre_awvalid", {31'b0, m_awvalid}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_valids", {27'b0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 32'h0);
        check("rst_mid_rsp", {31'b0, rsp_valid}, 32'h0);
        check("rst_mid_stall_hi", {31'b0, stall}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_stall_lo", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; aw_dly = 0; w_dly = 0;
        do_req(1'b1, 32'h0000_6008, 32'h89AB_CDEF, 4'hC);
        check("post_rst_done", t_done, 4);
        check("post_rst_hs", {d_aw[7:0], d_w[7:0], d_b[7:0], d_ar[7:0]}, 32'h0101_0100);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
